adc_pulse_gen: RTL
==================

Name: adc_pulse_gen

Overview:
- Synthetic ADC sample source that emits exponential-decay detector pulses in the same sample format the trapezoidal shaping filters consume.
- Used as on-chip stimulus ahead of the filter chain: linear rise over 2^RISE_SHIFT samples, then exponential decay with tau ≈ 2^DECAY_SHIFT samples, on top of a programmable baseline.
- Pulses start on an external trigger or on an internal periodic timer.

Parameters:
- SIZE_ADC_DATA, 14, output sample width (from package_settings)
- RISE_SHIFT, 2, rise length = 2^RISE_SHIFT samples
- DECAY_SHIFT, 5, per-sample decay: r -= r >> DECAY_SHIFT
- PERIOD_W, 16, auto-trigger period counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  sample strobe; when low, all state frozen
- trigger  in  1  one-cycle pulse request
- auto_mode  in  1  enables periodic internal trigger
- period  in  PERIOD_W  auto-trigger period in enabled cycles; 0 = auto disabled
- amplitude  in  SIZE_ADC_DATA  pulse height, latched at trigger
- baseline  in  SIZE_ADC_DATA  DC offset added to every sample
- output_data  out  SIZE_ADC_DATA  generated sample
- out_valid  out  1  output_data valid this cycle
- pulse_start  out  1  one-cycle flag, the cycle a pulse is accepted
- busy  out  1  state != IDLE
- dropped  out  1  sticky; a trigger was ignored during RISE; cleared by reset

Behaviour:
- Reset (async, active-high): state=IDLE, residual=0, period counter=0, output_data=0, out_valid=0, pulse_start=0, busy=0, dropped=0.
- Internal residual register is SIZE_ADC_DATA+1 bits and saturates at 2^(SIZE_ADC_DATA+1)-1.
- Trigger source: trig = trigger OR (auto_mode AND period!=0 AND cnt==period-1).
  - Counter increments on enabled cycles.
  - Counter wraps to 0 on auto fire, and on any accepted external trigger.
- FSM, advancing only when enable=1:
  - IDLE: on trig, latch amplitude and compute step = amplitude >> RISE_SHIFT. Go to RISE with rcnt=0. Assert pulse_start.
  - RISE:
    - For rcnt < 2^RISE_SHIFT-1: residual += step.
    - On the last cycle: residual += amplitude - step*(2^RISE_SHIFT-1). The ramp therefore ends exactly at start residual + amplitude.
    - Then go to DECAY. Any trig while in RISE is ignored and sets dropped.
  - DECAY:
    - Each cycle: residual -= max(residual >> DECAY_SHIFT, 1). This guarantees termination.
    - When residual reaches 0, go to IDLE.
    - trig in DECAY is accepted (pile-up): go to RISE from the current residual, with pulse_start asserted.
- Output stage (registered):
  - output_data = min(baseline + residual, 2^SIZE_ADC_DATA-1), using residual after the update.
  - out_valid = enable delayed one cycle.
- Latency: trig sampled at edge t → residual updated at edge t → first raised sample visible on output_data after edge t+1.
- enable=0: FSM, counters and residual hold. out_valid drops one cycle later. output_data holds its last value.
- amplitude=0: pulse accepted, residual unchanged; if residual=0, returns to IDLE after RISE.
- amplitude and period changes mid-pulse have no effect until the next accepted trigger (period does still govern the counter compare).
- Reset mid-pulse: immediate return to reset values; no partial ramp resumes.

Decomposition:
- package_settings: SIZE_ADC_DATA (shared).
- New package_settings_pgen:
  - state enum: IDLE, RISE, DECAY
  - RISE_SHIFT and DECAY_SHIFT defaults
  - PERIOD_W
- One sub-module, pgen_sat_add: saturating unsigned adder, used for the residual accumulate and the baseline add.

Test Plan:
- Reset: assert reset mid-run → all outputs 0 immediately. Release, enable=1, baseline=100 → output_data=100 two cycles later, out_valid=1, busy=0.
- Single pulse: baseline=100, amplitude=1024, trigger at t.
  - pulse_start at t.
  - Rise outputs: 356, 612, 868, 1124.
  - Decay outputs: 1092 (992+100), 1061, …
  - busy falls when residual=0; output returns to 100.
- Odd amplitude: amplitude=1023 → rise steps 255,255,255,258; peak = baseline+1023 exactly.
- Saturation: baseline=16000, amplitude=1000 → output clamps at 16383 and stays there until baseline+residual < 16383.
- Pile-up and drop:
  - Trigger again 2 cycles into RISE → ignored, dropped=1.
  - Trigger 10 cycles into DECAY → pulse_start, new ramp starts from current residual, peak = residual + amplitude.
- Auto mode and enable:
  - auto_mode=1, period=100 → pulse_start every 100 enabled cycles.
  - Deassert enable for 7 cycles → state frozen, out_valid=0, next pulse_start delayed by 7.
  - period=0 → no auto pulses.

Source files
------------

// File: rtl/adc_pulse_gen_pkg.sv
// Shared ADC sample format plus pulse-generator constants and FSM encodings.
package package_settings;
    localparam int unsigned SIZE_ADC_DATA = 14;
endpackage

package package_settings_pgen;
    localparam int unsigned PGEN_RISE_SHIFT  = 2;
    localparam int unsigned PGEN_DECAY_SHIFT = 5;
    localparam int unsigned PERIOD_W         = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RISE  = 2'd1;
    localparam logic [1:0] ST_DECAY = 2'd2;
endpackage

// File: rtl/adc_pulse_gen_if.sv
// Control and sample bus of the synthetic pulse source.
interface adc_pulse_gen_if;
    logic                                        enable;
    logic                                        trigger;
    logic                                        auto_mode;
    logic [package_settings_pgen::PERIOD_W-1:0]  period;
    logic [package_settings::SIZE_ADC_DATA-1:0]  amplitude;
    logic [package_settings::SIZE_ADC_DATA-1:0]  baseline;
    logic [package_settings::SIZE_ADC_DATA-1:0]  output_data;
    logic                                        out_valid;
    logic                                        pulse_start;
    logic                                        busy;
    logic                                        dropped;

    modport master (
        output enable, trigger, auto_mode, period, amplitude, baseline,
        input  output_data, out_valid, pulse_start, busy, dropped
    );

    modport slave (
        input  enable, trigger, auto_mode, period, amplitude, baseline,
        output output_data, out_valid, pulse_start, busy, dropped
    );
endinterface

// File: rtl/pgen_sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
module pgen_sat_add #(
    parameter int unsigned W = 15
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum_c
);
    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum_c = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
endmodule

// File: rtl/adc_pulse_gen.sv
// Synthetic detector pulse source: linear rise then exponential decay on a baseline.
// Trigger comes from the bus or from an internal period counter. RISE_SHIFT must be >= 1.
module adc_pulse_gen
    import package_settings::*;
    import package_settings_pgen::*;
#(
    parameter int unsigned RISE_SHIFT  = PGEN_RISE_SHIFT,
    parameter int unsigned DECAY_SHIFT = PGEN_DECAY_SHIFT
) (
    input  logic           clk,
    input  logic           reset,
    adc_pulse_gen_if.slave bus
);
    localparam int unsigned   DW        = SIZE_ADC_DATA;
    localparam int unsigned   RW        = SIZE_ADC_DATA + 1;
    localparam int unsigned   CW        = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam logic [CW-1:0] RCNT_LAST = CW'((1 << RISE_SHIFT) - 1);
    localparam logic [DW-1:0] STEP_MUL  = DW'((1 << RISE_SHIFT) - 1);

    logic [1:0]          r_state, w_state_nxt;
    logic [RW-1:0]       r_res;
    logic [RW-1:0]       w_res_sum, w_res_dec, w_res_nxt, w_dec, w_out_sum;
    logic [PERIOD_W-1:0] r_cnt;
    logic [CW-1:0]       r_rcnt, w_rcnt_nxt;
    logic [DW-1:0]       r_amp, r_step, w_amp_nxt, w_step_nxt;
    logic [DW-1:0]       w_step_new, w_last, w_add;
    logic [DW-1:0]       r_out;
    logic                r_valid, r_pstart, r_busy, r_dropped;
    logic                w_auto_fire, w_trig, w_accept, w_drop, w_do_dec;

    assign w_auto_fire = bus.auto_mode && (bus.period != '0) &&
                         (r_cnt == bus.period - PERIOD_W'(1));
    assign w_trig      = bus.trigger | w_auto_fire;
    assign w_step_new  = bus.amplitude >> RISE_SHIFT;

    // Final rise increment absorbs the truncation so the ramp lands exactly on +amplitude.
    assign w_last      = r_amp - r_step * STEP_MUL;

    // Decrement of at least 1 guarantees the tail reaches zero.
    assign w_dec       = ((r_res >> DECAY_SHIFT) == '0) ? RW'(1) : (r_res >> DECAY_SHIFT);
    assign w_res_dec   = r_res - w_dec;
    assign w_res_nxt   = w_do_dec ? w_res_dec : w_res_sum;

    pgen_sat_add #(.W(RW)) u_acc (
        .i_a     (r_res),
        .i_b     ({1'b0, w_add}),
        .o_sum_c (w_res_sum)
    );

    pgen_sat_add #(.W(RW)) u_out (
        .i_a     ({1'b0, bus.baseline}),
        .i_b     (r_res),
        .o_sum_c (w_out_sum)
    );

    // Next-state and datapath select.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_amp_nxt   = r_amp;
        w_step_nxt  = r_step;
        w_add       = '0;
        w_do_dec    = 1'b0;
        w_accept    = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            ST_IDLE: w_accept = w_trig;
            ST_RISE: begin
                w_drop = w_trig;
                if (r_rcnt == RCNT_LAST) begin
                    w_add       = w_last;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = ((r_res == '0) && (w_last == '0)) ? ST_IDLE : ST_DECAY;
                end else begin
                    w_add      = r_step;
                    w_rcnt_nxt = r_rcnt + CW'(1);
                end
            end
            ST_DECAY: begin
                if (w_trig) begin
                    w_accept = 1'b1;
                end else begin
                    w_do_dec = 1'b1;
                    if (w_res_dec == '0) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Accepted pulse applies its first rise step on the accepting edge.
        if (w_accept) begin
            w_state_nxt = ST_RISE;
            w_rcnt_nxt  = CW'(1);
            w_amp_nxt   = bus.amplitude;
            w_step_nxt  = w_step_new;
            w_add       = w_step_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_res     <= '0;
            r_cnt     <= '0;
            r_rcnt    <= '0;
            r_amp     <= '0;
            r_step    <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_pstart  <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_valid  <= bus.enable;
            r_pstart <= bus.enable & w_accept;
            if (bus.enable) begin
                r_state   <= w_state_nxt;
                r_res     <= w_res_nxt;
                r_rcnt    <= w_rcnt_nxt;
                r_amp     <= w_amp_nxt;
                r_step    <= w_step_nxt;
                r_busy    <= (w_state_nxt != ST_IDLE);
                r_dropped <= r_dropped | w_drop;
                r_cnt     <= (w_auto_fire || (w_accept && bus.trigger)) ?
                             '0 : r_cnt + PERIOD_W'(1);
                r_out     <= w_out_sum[RW-1] ? '1 : w_out_sum[DW-1:0];
            end
        end
    end

    assign bus.output_data = r_out;
    assign bus.out_valid   = r_valid;
    assign bus.pulse_start = r_pstart;
    assign bus.busy        = r_busy;
    assign bus.dropped     = r_dropped;
endmodule
